// File: rtl/instr_word_encoder_if.sv
// Descriptor stream into the instruction encoder: one operation descriptor per
// valid/ready handshake, plus the seal request that terminates a program.
interface instr_word_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic        seal;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;

    modport master (
        output in_valid, seal, op, rd, rs1, rs2, imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, seal, op, rd, rs1, rs2, imm,
        output in_ready
    );
endinterface

// File: rtl/instr_word_encoder.sv
// Encodes RV32 operation descriptors into instruction words and streams them to
// instruction memory at consecutive word addresses, closing the program with a NOP.
module instr_word_encoder #(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int unsigned        DEPTH     = 64,
    localparam int unsigned       CW        = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   restart,
    instr_word_encoder_if.slave    desc,
    output logic                   imem_we,
    output logic [ADDR_W-1:0]      imem_addr,
    output logic [31:0]            imem_wdata,
    output logic [CW-1:0]          count,
    output logic [7:0]             err_count,
    output logic                   error,
    output logic                   done
);

    localparam logic [31:0] Nop = 32'h0000_0013;

    typedef enum logic [0:0] {StLoad, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [7:0]          err_q, err_d;
    logic                error_q, error_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                legal;
    logic [31:0]         enc;
    logic                accept;

    // Encoder: only the opcode/funct3/funct7 combinations the decoder accepts.
    always_comb begin
        legal = 1'b1;
        enc   = 32'h0;
        case (desc.op)
            4'd0: enc = {7'b0000000, desc.rs2, desc.rs1, 3'b000, desc.rd, 7'b0110011};
            4'd1: enc = {7'b0100000, desc.rs2, desc.rs1, 3'b000, desc.rd, 7'b0110011};
            4'd2: enc = {7'b0000000, desc.rs2, desc.rs1, 3'b111, desc.rd, 7'b0110011};
            4'd3: enc = {7'b0000000, desc.rs2, desc.rs1, 3'b110, desc.rd, 7'b0110011};
            4'd4: enc = {7'b0000001, desc.rs2, desc.rs1, 3'b000, desc.rd, 7'b0110011};
            4'd5: enc = {desc.imm, desc.rs1, 3'b000, desc.rd, 7'b0010011};
            4'd6: begin
                legal = (desc.imm[11:5] == 7'b0);
                enc   = {7'b0000000, desc.imm[4:0], desc.rs1, 3'b001, desc.rd, 7'b0010011};
            end
            4'd7: enc = {desc.imm, desc.rs1, 3'b010, desc.rd, 7'b0000011};
            4'd8: enc = {desc.imm[11:5], desc.rs2, desc.rs1, 3'b010, desc.imm[4:0], 7'b0100011};
            default: legal = 1'b0;
        endcase
    end

    assign desc.in_ready = (state_q == StLoad) && (count_q < CW'(DEPTH - 1))
                           && !desc.seal && !restart;
    assign accept = desc.in_valid && desc.in_ready;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        err_d   = err_q;
        error_d = error_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (restart) begin
            state_d = StLoad;
            wptr_d  = BASE_ADDR;
            count_d = '0;
            err_d   = '0;
            error_d = 1'b0;
        end else if (state_q == StLoad) begin
            if (desc.seal) begin
                we_d    = 1'b1;
                addr_d  = wptr_q;
                wdata_d = Nop;
                state_d = StDone;
            end else if (accept) begin
                if (legal) begin
                    we_d    = 1'b1;
                    addr_d  = wptr_q;
                    wdata_d = enc;
                    wptr_d  = wptr_q + ADDR_W'(4);
                    count_d = count_q + CW'(1);
                end else begin
                    err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                    error_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StLoad;
            wptr_q  <= BASE_ADDR;
            count_q <= '0;
            err_q   <= '0;
            error_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            error_q <= error_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign err_count  = err_q;
    assign error      = error_q;
    assign done       = (state_q == StDone);

endmodule

// File: doc/instr_word_encoder.md
# instr_word_encoder

Sequential RV32 instruction encoder that turns operation descriptors (op select, rd, rs1, rs2, imm) into 32-bit instruction words and streams them into instruction memory at consecutive word addresses. It covers the same instruction subset the control-logic decoder supports, and encodes exactly the opcode/funct3/funct7 combinations that the decoder accepts. It sits between the test/program-load path and the instruction memory write port. It accepts one descriptor per cycle under a valid/ready handshake, and terminates a program with a NOP on request.

## Interface
- ADDR_W, 32, instruction memory byte-address width
- BASE_ADDR, 0, byte address of first written word
- DEPTH, 64, words available including the terminating NOP slot (≥2)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- restart  in  1  synchronous soft clear of pointer, counts, flags, state
- in_valid  in  1  descriptor present
- in_ready  out  1  descriptor accepted when in_valid && in_ready
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 ADDI, 6 SLLI, 7 LW, 8 SW, 9–15 illegal
- rd, rs1, rs2  in  5 each  register indices
- imm  in  12  immediate (ADDI/LW/SW), shamt in imm[4:0] for SLLI
- seal  in  1  append NOP and finish
- imem_we  out  1  write strobe, one cycle per word
- imem_addr  out  ADDR_W  byte address of presented word
- imem_wdata  out  32  encoded instruction
- count  out  clog2(DEPTH)+1  words written excluding NOP
- err_count  out  8  illegal descriptors dropped, saturating at 255
- error  out  1  sticky: any illegal descriptor since reset/restart
- done  out  1  program sealed

## Operation
- FSM states: LOAD, DONE. Reset and restart both go to LOAD.
- in_ready = (state==LOAD) && (count < DEPTH-1) && !seal && !restart.
  - This is combinational from registers plus the seal and restart inputs.
- Encodings (opcode, funct3, funct7):
  - ADD: 0110011, 000, 0000000
  - SUB: 0110011, 000, 0100000
  - OR: 0110011, 110, 0000000
  - AND: 0110011, 111, 0000000
  - MUL: 0110011, 000, 0000001
  - ADDI: I-type, 0010011, 000
  - SLLI: 0010011, 001, imm[11:5] must be 0, else illegal
  - LW: I-type, 0000011, 010
  - SW: S-type, 0100011, 010, imm[11:5]→[31:25], imm[4:0]→[11:7]
- Unused fields are zero: rs2 for I-type, rd for SW.
- On a legal handshake:
  - Register imem_wdata and imem_addr = wptr, pulse imem_we.
  - Advance wptr by 4 and increment count.
- On an illegal handshake (op 9–15, or SLLI with nonzero imm[11:5]):
  - The descriptor is consumed with no write.
  - err_count increments, saturating at 255; error is set.
  - count and wptr are unchanged.
- seal in LOAD:
  - Write 0x00000013 (addi x0,x0,0) at wptr, go to DONE, set done.
  - count does not increment.
  - A NOP slot always remains, because user words are capped at DEPTH-1.
- seal in DONE is ignored. In DONE, in_ready=0 and nothing is written until restart.
- restart:
  - Clears wptr to BASE_ADDR; clears count, err_count, error and done; state goes to LOAD.
  - No write and no accept that cycle. restart has priority over seal and in_valid.
- Arithmetic: wptr wraps modulo 2^ADDR_W. DEPTH bounds it in practice.

## Timing
- Reset values:
  - imem_we 0, imem_addr BASE_ADDR, imem_wdata 0
  - count 0, err_count 0, error 0, done 0, state LOAD
  - in_ready is 1 once reset deasserts.
- Latency: handshake at edge N → imem_we/addr/wdata valid for the single cycle after edge N. Throughput is 1 word/cycle.
- Seal sampled at edge N → NOP write and done=1 both visible after edge N. done stays high until reset or restart.
- imem_we deasserts in every cycle without a fresh write. There is no backpressure from memory.
- reset or restart mid-stream drops any write not yet presented. A write already presented completes its single cycle before the clear takes effect.
- Full: in the cycle count reaches DEPTH-1, in_ready falls combinationally and only seal or restart make progress.

## Test plan
- Reset, then ADD rd=3 rs1=1 rs2=2 → one cycle later imem_we=1, addr=0x0, wdata=0x002081B3, count=1.
- Back-to-back SUB x5,x6,x7; MUL x3,x1,x2; SLLI x2,x2,3 → wdata 0x407302B3, 0x022081B3, 0x00311113 at addr 0x0/0x4/0x8 on consecutive cycles.
- ADDI x1,x0,5; LW x4,8(x2); SW x4,12(x2) → 0x00500093, 0x00812203, 0x00412623.
- op=12, then SLLI with imm=0x403 → no imem_we, err_count=2, error=1, count unchanged, the next legal word lands at the unchanged address.
- DEPTH=4: three ADDs accepted, then in_ready=0 with in_valid held high. seal → NOP 0x00000013 at addr 0xC, done=1, count=3. A further seal is ignored.
- Mid-stream restart asserted together with in_valid and seal → no accept, no write. Next cycle: count=0, done=0, error=0, and the next ADD writes at BASE_ADDR.
